// File: rtl/code_conv_pkg.sv
// Shared types and constants for the code-converter arbiter.
// Conversion modes and conversion-counter sizing.
package code_conv_pkg;

  typedef enum logic {
    MODE_BIN2GRAY = 1'b0,
    MODE_GRAY2BIN = 1'b1
  } conv_mode_e;

  localparam int COUNT_W = 16;
  localparam logic [COUNT_W-1:0] COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/code_conv_arbiter_if.sv
// Request/response bundle between producers, arbiter and consumer.
// master = producer/consumer side, slave = arbiter side.
interface code_conv_arbiter_if
  import code_conv_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) ();

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_mode;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH-1:0]         rsp_data;
  logic [ID_W-1:0]          rsp_id;
  logic [COUNT_W-1:0]       conv_count;

  modport master (
    output req_valid, req_data, req_mode, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, conv_count
  );

  modport slave (
    input  req_valid, req_data, req_mode, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, conv_count
  );

endinterface

// File: rtl/code_conv_unit.sv
// Combinational binary/Gray converter shared by all requesters.
// Gray->binary path only exists when GRAY2BIN_EN is defined.
module code_conv_unit
  import code_conv_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] data,
  input  conv_mode_e       mode,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] gray;

  assign gray = data ^ (data >> 1);

`ifdef GRAY2BIN_EN
  logic [WIDTH-1:0] bin;

  // Running XOR from the MSB down recovers the binary word
  always_comb begin
    bin = '0;
    bin[WIDTH-1] = data[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ data[i];
    end
  end

  assign result = (mode == MODE_GRAY2BIN) ? bin : gray;
`else
  logic mode_unused;

  assign mode_unused = mode;
  assign result = gray;
`endif

endmodule

// File: rtl/code_conv_arbiter.sv
// Round-robin arbiter feeding one shared code converter.
// Build option: GRAY2BIN_EN enables the Gray->binary direction.
module code_conv_arbiter
  import code_conv_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input logic              clk,
  input logic              rst,
  code_conv_arbiter_if.slave bus
);

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    gnt_idx;
  logic [ID_W-1:0]    ptr_nxt;
  logic               gnt_any;
  logic               can_accept;
  logic               grant;
  logic [WIDTH-1:0]   gnt_data;
  logic [WIDTH-1:0]   conv_data;
  conv_mode_e         gnt_mode;
  logic [COUNT_W-1:0] count;

  assign can_accept = !bus.rsp_valid || bus.rsp_ready;

  // First valid requester at or after rr_ptr, wrapping around
  always_comb begin
    int j;
    j = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(rr_ptr) + k) % NUM_REQ;
      if (!gnt_any && bus.req_valid[j]) begin
        gnt_any = 1'b1;
        gnt_idx = ID_W'(j);
      end
    end
  end

  assign grant   = can_accept && gnt_any && !rst;
  assign ptr_nxt = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0
                 : gnt_idx + 1'b1;

  assign bus.req_ready = grant ? (NUM_REQ'(1) << gnt_idx) : '0;

  assign gnt_data = bus.req_data[int'(gnt_idx)*WIDTH +: WIDTH];
  assign gnt_mode = conv_mode_e'(bus.req_mode[gnt_idx]);

  code_conv_unit #(
    .WIDTH (WIDTH)
  ) u_unit (
    .data   (gnt_data),
    .mode   (gnt_mode),
    .result (conv_data)
  );

  // Output buffer, round-robin pointer and transfer counter
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_id    <= '0;
      rr_ptr        <= '0;
      count         <= '0;
    end else begin
      if (grant) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_data  <= conv_data;
        bus.rsp_id    <= gnt_idx;
        rr_ptr        <= ptr_nxt;
      end else if (bus.rsp_ready) begin
        bus.rsp_valid <= 1'b0;
      end
      if (bus.rsp_valid && bus.rsp_ready && count != COUNT_MAX) begin
        count <= count + 1'b1;
      end
    end
  end

  assign bus.conv_count = count;

endmodule
